// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Registered fixed-priority encoder built as a log2 select tree.
//               Optional request mask enabled by PRIORITY_ENCODER_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder #(
   parameter int WIDTH             = 4,
   parameter int LSB_HIGH_PRIORITY = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         input_unencoded,
`ifdef PRIORITY_ENCODER_MASK_EN
   input  logic [WIDTH-1:0]         input_mask,
`endif
   output logic                     output_valid,
   output logic [$clog2(WIDTH)-1:0] output_encoded,
   output logic [WIDTH-1:0]         output_unencoded
);

   localparam int c_levels = $clog2(WIDTH);
   localparam int c_padded = 1 << c_levels;

   logic [WIDTH-1:0]    w_req;
   logic [c_padded-1:0] w_leaf;

   // Heap-ordered tree: node 1 is the root, node k has children 2k and 2k+1,
   // leaves sit at c_padded + bit index.
   logic                w_node_valid [1:2*c_padded-1];
   logic [c_levels-1:0] w_node_index [1:2*c_padded-1];

   logic                w_valid;
   logic [c_levels-1:0] w_encoded;
   logic [WIDTH-1:0]    w_one_hot;

   logic                r_valid;
   logic [c_levels-1:0] r_encoded;
   logic [WIDTH-1:0]    r_one_hot;

`ifdef PRIORITY_ENCODER_MASK_EN
   assign w_req = input_unencoded & input_mask;
`else
   assign w_req = input_unencoded;
`endif

   // Zero padding keeps the extra leaves permanently idle
   assign w_leaf = c_padded'(w_req);

   generate
      for (genvar n = 0; n < c_padded; n++) begin : g_leaf
         assign w_node_valid[c_padded + n] = w_leaf[n];
         assign w_node_index[c_padded + n] = '0;
      end

      for (genvar l = 1; l <= c_levels; l++) begin : g_level
         for (genvar n = 0; n < (c_padded >> l); n++) begin : g_node
            localparam int                  c_node    = (c_padded >> l) + n;
            localparam logic [c_levels-1:0] c_sel_bit = c_levels'(1) << (l - 1);

            logic w_take_hi;

            if (LSB_HIGH_PRIORITY != 0) begin : g_lsb
               assign w_take_hi = !w_node_valid[2*c_node];
            end else begin : g_msb
               assign w_take_hi = w_node_valid[2*c_node+1];
            end

            assign w_node_valid[c_node] = w_node_valid[2*c_node] | w_node_valid[2*c_node+1];
            assign w_node_index[c_node] = w_take_hi ? (w_node_index[2*c_node+1] | c_sel_bit)
                                                    :  w_node_index[2*c_node];
         end
      end
   endgenerate

   // Gating matters in LSB mode: an empty tree otherwise steers to the high side
   assign w_valid   = w_node_valid[1];
   assign w_encoded = w_valid ? w_node_index[1] : '0;
   assign w_one_hot = w_valid ? (WIDTH'(1) << w_encoded) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_encoded <= '0;
         r_one_hot <= '0;
      end else begin
         r_valid   <= w_valid;
         r_encoded <= w_encoded;
         r_one_hot <= w_one_hot;
      end
   end

   assign output_valid     = r_valid;
   assign output_encoded   = r_encoded;
   assign output_unencoded = r_one_hot;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder
// Description : Self-checking bench for priority_encoder (WIDTH 4/5, both priorities).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder;

   typedef struct packed {
      logic       v;
      logic [2:0] enc;
      logic [4:0] un;
   } res_t;

   typedef struct packed {
      res_t a;   // WIDTH 4, MSB priority
      res_t b;   // WIDTH 4, LSB priority
      res_t c;   // WIDTH 5, MSB priority
      res_t d;   // WIDTH 5, LSB priority
   } exp_t;

   typedef struct packed {
      logic [3:0] in;
      res_t       msb;
      res_t       lsb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in4 = '0;
   logic [4:0] in5 = '0;
   logic [3:0] m4  = '1;
   logic [4:0] m5  = '1;

   logic       va, vb, vc, vd;
   logic [1:0] ea, eb;
   logic [2:0] ec, ed;
   logic [3:0] ua, ub;
   logic [4:0] uc, ud;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

`ifdef PRIORITY_ENCODER_MASK_EN
   priority_encoder #(.WIDTH(4), .LSB_HIGH_PRIORITY(0)) u_a (.clk(clk), .rst(rst), .input_unencoded(in4), .input_mask(m4), .output_valid(va), .output_encoded(ea), .output_unencoded(ua));
   priority_encoder #(.WIDTH(4), .LSB_HIGH_PRIORITY(1)) u_b (.clk(clk), .rst(rst), .input_unencoded(in4), .input_mask(m4), .output_valid(vb), .output_encoded(eb), .output_unencoded(ub));
   priority_encoder #(.WIDTH(5), .LSB_HIGH_PRIORITY(0)) u_c (.clk(clk), .rst(rst), .input_unencoded(in5), .input_mask(m5), .output_valid(vc), .output_encoded(ec), .output_unencoded(uc));
   priority_encoder #(.WIDTH(5), .LSB_HIGH_PRIORITY(1)) u_d (.clk(clk), .rst(rst), .input_unencoded(in5), .input_mask(m5), .output_valid(vd), .output_encoded(ed), .output_unencoded(ud));
`else
   priority_encoder #(.WIDTH(4), .LSB_HIGH_PRIORITY(0)) u_a (.clk(clk), .rst(rst), .input_unencoded(in4), .output_valid(va), .output_encoded(ea), .output_unencoded(ua));
   priority_encoder #(.WIDTH(4), .LSB_HIGH_PRIORITY(1)) u_b (.clk(clk), .rst(rst), .input_unencoded(in4), .output_valid(vb), .output_encoded(eb), .output_unencoded(ub));
   priority_encoder #(.WIDTH(5), .LSB_HIGH_PRIORITY(0)) u_c (.clk(clk), .rst(rst), .input_unencoded(in5), .output_valid(vc), .output_encoded(ec), .output_unencoded(uc));
   priority_encoder #(.WIDTH(5), .LSB_HIGH_PRIORITY(1)) u_d (.clk(clk), .rst(rst), .input_unencoded(in5), .output_valid(vd), .output_encoded(ed), .output_unencoded(ud));
`endif

   function automatic res_t mk(input logic v, input logic [2:0] e, input logic [4:0] u);
      res_t r;
      r.v   = v;
      r.enc = e;
      r.un  = u;
      return r;
   endfunction

   // Linear-scan reference model
   function automatic res_t model(input logic [4:0] req, input int w, input bit lsb);
      res_t r = '0;
      for (int i = 0; i < w; i++) begin
         if (req[i] && !(lsb && r.v)) begin
            r.v   = 1'b1;
            r.enc = i[2:0];
         end
      end
      if (r.v) r.un = 5'd1 << r.enc;
      return r;
   endfunction

   function automatic exp_t model_all(input logic [3:0] a4, input logic [4:0] b5);
      exp_t e;
      e.a = model({1'b0, a4 & m4}, 4, 1'b0);
      e.b = model({1'b0, a4 & m4}, 4, 1'b1);
      e.c = model(b5 & m5, 5, 1'b0);
      e.d = model(b5 & m5, 5, 1'b1);
      return e;
   endfunction

   task automatic cmp(input string name, input res_t act, input res_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got v=%0b enc=%0d un=%b, expected v=%0b enc=%0d un=%b",
                  name, act.v, act.enc, act.un, exp.v, exp.enc, exp.un);
      end
   endtask

   task automatic check_all(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty, got nothing expected", tag);
         return;
      end
      e = exp_q.pop_front();
      cmp({tag, "/w4msb"}, mk(va, 3'(ea), 5'(ua)), e.a);
      cmp({tag, "/w4lsb"}, mk(vb, 3'(eb), 5'(ub)), e.b);
      cmp({tag, "/w5msb"}, mk(vc, ec, uc), e.c);
      cmp({tag, "/w5lsb"}, mk(vd, ed, ud), e.d);
   endtask

   task automatic drive(input string tag, input logic [3:0] a, input logic [4:0] b, input exp_t e);
      @(negedge clk);
      in4 = a;
      in5 = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   vec_t tbl[9];
   exp_t e;

   initial begin
      tbl[0] = '{4'b0000, mk(1'b0, 3'd0, 5'b00000), mk(1'b0, 3'd0, 5'b00000)};
      tbl[1] = '{4'b0001, mk(1'b1, 3'd0, 5'b00001), mk(1'b1, 3'd0, 5'b00001)};
      tbl[2] = '{4'b0010, mk(1'b1, 3'd1, 5'b00010), mk(1'b1, 3'd1, 5'b00010)};
      tbl[3] = '{4'b0100, mk(1'b1, 3'd2, 5'b00100), mk(1'b1, 3'd2, 5'b00100)};
      tbl[4] = '{4'b1000, mk(1'b1, 3'd3, 5'b01000), mk(1'b1, 3'd3, 5'b01000)};
      tbl[5] = '{4'b1100, mk(1'b1, 3'd3, 5'b01000), mk(1'b1, 3'd2, 5'b00100)};
      tbl[6] = '{4'b1010, mk(1'b1, 3'd3, 5'b01000), mk(1'b1, 3'd1, 5'b00010)};
      tbl[7] = '{4'b0110, mk(1'b1, 3'd2, 5'b00100), mk(1'b1, 3'd1, 5'b00010)};
      tbl[8] = '{4'b1111, mk(1'b1, 3'd3, 5'b01000), mk(1'b1, 3'd0, 5'b00001)};

      // Reset held with a pending request: outputs must stay zero
      in4 = 4'b0001;
      in5 = 5'b00001;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('0);
      check_all("rst_hold");

      // First edge after release loads the current input
      @(negedge clk);
      rst = 1'b0;
      e   = model_all(in4, in5);
      e.a = mk(1'b1, 3'd0, 5'b00001);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_all("rst_release");

      for (int i = 0; i < 9; i++) begin
         e   = model_all(tbl[i].in, {tbl[i].in[0], tbl[i].in});
         e.a = tbl[i].msb;
         e.b = tbl[i].lsb;
         drive($sformatf("tbl%0d", i), tbl[i].in, {tbl[i].in[0], tbl[i].in}, e);
      end

      // Top real bit of a non-power-of-two width
      e   = model_all(4'b0000, 5'b10000);
      e.c = mk(1'b1, 3'd4, 5'b10000);
      e.d = mk(1'b1, 3'd4, 5'b10000);
      drive("w5_top", 4'b0000, 5'b10000, e);

      // Asynchronous reset mid-stream, away from any clock edge
      drive("pre_rst", 4'b1000, 5'b11000, model_all(4'b1000, 5'b11000));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.push_back('0);
      check_all("async_rst");
      @(negedge clk);
      in4 = 4'b0100;
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      check_all("async_hold");
      @(negedge clk);
      rst = 1'b0;
      in4 = 4'b0010;
      in5 = 5'b00011;
      e   = model_all(in4, in5);
      e.a = mk(1'b1, 3'd1, 5'b00010);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_all("async_release");

`ifdef PRIORITY_ENCODER_MASK_EN
      m4  = 4'b0110;
      e   = model_all(4'b1111, 5'b11111);
      e.a = mk(1'b1, 3'd2, 5'b00100);
      drive("mask_0110", 4'b1111, 5'b11111, e);
      m4  = 4'b0000;
      m5  = 5'b01010;
      e   = model_all(4'b1111, 5'b11111);
      e.a = '0;
      e.b = '0;
      drive("mask_0000", 4'b1111, 5'b11111, e);
      m4 = '1;
      m5 = '1;
`endif

      for (int i = 0; i < 40; i++) begin
         logic [3:0] ra;
         logic [4:0] rb;
         ra = 4'($urandom);
         rb = 5'($urandom);
         drive($sformatf("rand%0d", i), ra, rb, model_all(ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
